// File: rtl/id_pkg.sv
// Shared defaults and state encoding for the ID search engine.
package id_pkg;

    localparam int unsigned DEF_ID_W      = 25;
    localparam int unsigned DEF_ADDR_W    = 4;
    localparam int unsigned DEF_DEPTH     = 5;
    localparam int unsigned DEF_MAX_FAILS = 3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StCmp   = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/fail_lock_ctr.sv
// Saturating count of consecutive failed searches; raises the lock flag at MAX_FAILS.
module fail_lock_ctr
    import id_pkg::*;
#(
    parameter int unsigned MAX_FAILS = DEF_MAX_FAILS
) (
    input  logic clk,
    input  logic rst,
    input  logic hit,
    input  logic miss,
    input  logic clear,
    output logic locked
);

    localparam int unsigned CNT_W = $clog2(MAX_FAILS + 1);

    logic [CNT_W-1:0] fail_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_cnt <= '0;
            locked   <= 1'b0;
        end else if (clear) begin
            fail_cnt <= '0;
            locked   <= 1'b0;
        end else if (hit) begin
            fail_cnt <= '0;
        end else if (miss && (fail_cnt != CNT_W'(MAX_FAILS))) begin
            fail_cnt <= fail_cnt + 1'b1;
            // Lock lands on the same edge that enters DONE for the final miss.
            if (fail_cnt == CNT_W'(MAX_FAILS - 1)) begin
                locked <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/id_search_fsm.sv
// Sequential ID lookup: walks a synchronous-read ROM and reports first match and its index.
// Optional consecutive-miss lockout is built when FAIL_LOCK_EN is defined.
module id_search_fsm
    import id_pkg::*;
#(
    parameter int unsigned ID_W   = DEF_ID_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
`ifdef FAIL_LOCK_EN
    ,
    parameter int unsigned MAX_FAILS = DEF_MAX_FAILS
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ID_W-1:0]   id_in,
    input  logic [ID_W-1:0]   rom_data,
    input  logic              unlock,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              busy,
    output logic              done,
    output logic              match,
    output logic [ADDR_W-1:0] match_idx,
    output logic              locked
);

    state_e            state;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] idx;
    logic              is_hit;
    logic              is_last;
    logic              accept;

    assign is_hit  = (rom_data == id_q);
    assign is_last = (idx == ADDR_W'(DEPTH - 1));

`ifdef FAIL_LOCK_EN
    logic unlock_now;

    // unlock takes priority over a simultaneous start.
    assign unlock_now = (state == StIdle) && unlock;
    assign accept     = (state == StIdle) && start && !locked && !unlock;

    fail_lock_ctr #(
        .MAX_FAILS (MAX_FAILS)
    ) u_fail_lock_ctr (
        .clk    (clk),
        .rst    (rst),
        .hit    ((state == StCmp) && is_hit),
        .miss   ((state == StCmp) && !is_hit && is_last),
        .clear  (unlock_now),
        .locked (locked)
    );
`else
    logic unused_unlock;

    assign unused_unlock = unlock;
    assign accept        = (state == StIdle) && start;
    assign locked        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            id_q      <= '0;
            idx       <= '0;
            rom_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            match     <= 1'b0;
            match_idx <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (accept) begin
                        id_q      <= id_in;
                        idx       <= '0;
                        rom_addr  <= '0;
                        match     <= 1'b0;
                        match_idx <= '0;
                        busy      <= 1'b1;
                        state     <= StFetch;
                    end
                end
                StFetch: begin
                    state <= StCmp;
                end
                StCmp: begin
                    if (is_hit) begin
                        match     <= 1'b1;
                        match_idx <= idx;
                        done      <= 1'b1;
                        state     <= StDone;
                    end else if (is_last) begin
                        match <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end else begin
                        idx      <= idx + 1'b1;
                        rom_addr <= idx + 1'b1;
                        state    <= StFetch;
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_id_search_fsm.sv
// Self-checking bench for id_search_fsm against a behavioural ROM and search model.
module tb_id_search_fsm;

    localparam int ID_W   = 25;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 5;
    localparam int LIMIT  = 60;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ID_W-1:0]   id_in;
    logic [ID_W-1:0]   rom_data;
    logic              unlock;
    logic [ADDR_W-1:0] rom_addr;
    logic              busy;
    logic              done;
    logic              match;
    logic [ADDR_W-1:0] match_idx;
    logic              locked;

    logic [ID_W-1:0] rom [DEPTH];

    int checks   = 0;
    int failures = 0;

    id_search_fsm dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .id_in     (id_in),
        .rom_data  (rom_data),
        .unlock    (unlock),
        .rom_addr  (rom_addr),
        .busy      (busy),
        .done      (done),
        .match     (match),
        .match_idx (match_idx),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    // Behavioural ROM with one-cycle read latency.
    always @(posedge clk) begin
        rom_data <= (int'(rom_addr) < DEPTH) ? rom[int'(rom_addr)] : '0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One search from IDLE; the model is a linear first-match scan of the ROM table.
    task automatic run_search(input logic [ID_W-1:0] id, input int disturb, input bit pre_unlock);
        bit exp_hit = 1'b0;
        int exp_idx = 0;
        int exp_lat;
        int exp_last;
        int n = 0;
        int last_addr = -1;
        bit got = 1'b0;
        bit addr_ok = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (!exp_hit && rom[i] == id) begin
                exp_hit = 1'b1;
                exp_idx = i;
            end
        end
        exp_lat  = exp_hit ? 2 * exp_idx + 3 : 2 * DEPTH + 1;
        exp_last = exp_hit ? exp_idx : DEPTH - 1;
        if (pre_unlock) begin
            @(negedge clk);
            unlock = 1'b1;
            @(negedge clk);
            unlock = 1'b0;
        end
        @(negedge clk);
        start = 1'b1;
        id_in = id;
        @(posedge clk);
        #1;
        start = 1'b0;
        id_in = ID_W'($urandom);
        for (int e = 1; e <= LIMIT; e++) begin
            @(negedge clk);
            if (e == disturb) begin
                start = 1'b1;
                id_in = ID_W'($urandom);
            end else begin
                start = 1'b0;
            end
            if (int'(rom_addr) != last_addr) begin
                if (int'(rom_addr) != last_addr + 1) addr_ok = 1'b0;
                last_addr = int'(rom_addr);
            end
            if (done) begin
                got = 1'b1;
                n = e;
                break;
            end
        end
        start = 1'b0;
        check("done_seen", 32'(got), 32'd1);
        check("latency", 32'(n), 32'(exp_lat));
        check("match", 32'(match), 32'(exp_hit));
        check("match_idx", 32'(match_idx), 32'(exp_hit ? exp_idx : 0));
        check("busy_in_done", 32'(busy), 32'd1);
        check("addr_last", 32'(last_addr), 32'(exp_last));
        check("addr_order", 32'(addr_ok), 32'd1);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("busy_clear", 32'(busy), 32'd0);
        check("match_held", 32'(match), 32'(exp_hit));
    endtask

    initial begin
        logic [ID_W-1:0] id;
        rom[0] = 25'd25481340;
        rom[1] = 25'd25481395;
        rom[2] = 25'd25435478;
        rom[3] = 25'd25697485;
        rom[4] = 25'd25369875;
        rst    = 1'b1;
        start  = 1'b0;
        unlock = 1'b0;
        id_in  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_match", 32'(match), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        rst = 1'b0;

        run_search(25'd25481340, 0, 1'b1);
        run_search(25'd25369875, 0, 1'b1);
        run_search(25'd12345678, 0, 1'b1);
        run_search(25'd0, 0, 1'b1);
        // start during busy with another ID must be ignored
        run_search(25'd25435478, 2, 1'b1);

        // Asynchronous reset during CMP of entry 2 (entered on edge 5).
        @(negedge clk);
        start = 1'b1;
        id_in = rom[4];
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_match", 32'(match), 32'd0);
        check("arst_idx", 32'(match_idx), 32'd0);
        check("arst_addr", 32'(rom_addr), 32'd0);
        repeat (2) @(negedge clk);
        check("arst_no_done", 32'(done), 32'd0);
        rst = 1'b0;
        run_search(rom[3], 0, 1'b1);

        for (int t = 0; t < 8; t++) begin
            if ($urandom_range(0, 2) == 0) id = ID_W'($urandom);
            else id = rom[$urandom_range(0, DEPTH - 1)];
            run_search(id, (t % 2 == 0) ? 0 : 2, 1'b1);
        end

`ifdef FAIL_LOCK_EN
        run_search(25'd111, 0, 1'b1);
        check("lock_after1", 32'(locked), 32'd0);
        run_search(25'd222, 0, 1'b0);
        check("lock_after2", 32'(locked), 32'd0);
        run_search(25'd333, 0, 1'b0);
        check("lock_after3", 32'(locked), 32'd1);
        @(negedge clk);
        start = 1'b1;
        id_in = rom[0];
        repeat (4) @(negedge clk);
        check("locked_ignores_start", 32'(busy), 32'd0);
        start  = 1'b1;
        unlock = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        unlock = 1'b0;
        check("unlock_clears", 32'(locked), 32'd0);
        check("unlock_drops_start", 32'(busy), 32'd0);
        run_search(rom[1], 0, 1'b0);
        check("post_unlock_locked", 32'(locked), 32'd0);
`else
        check("locked_tied", 32'(locked), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
